// File: rtl/cci_mpf_event_counters.sv
// Per-event counters for the MPF shim event wires, with a 2-stage indexed read port and per-index/global clear.
// Optional build macro CCI_MPF_EVENT_CTR_SATURATE_EN: counters saturate at all-ones instead of wrapping.
module cci_mpf_event_counters #(
  parameter int N_EVENTS  = 13,
  parameter int CTR_WIDTH = 48,
  parameter int IDX_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_EVENTS-1:0]  event_in,
  input  logic                 clr_all,
  input  logic                 clr_valid,
  input  logic [IDX_WIDTH-1:0] clr_idx,
  input  logic                 rd_valid,
  input  logic [IDX_WIDTH-1:0] rd_idx,
  output logic                 rd_rsp_valid,
  output logic [IDX_WIDTH-1:0] rd_rsp_idx,
  output logic [63:0]          rd_rsp_data
);

  localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;

  logic [N_EVENTS-1:0]  event_d, event_q;
  logic [CTR_WIDTH-1:0] cnt_d [N_EVENTS];
  logic [CTR_WIDTH-1:0] cnt_q [N_EVENTS];
  logic [N_EVENTS-1:0]  ovf_d, ovf_q;

  logic                 r1_valid_d, r1_valid_q;
  logic [IDX_WIDTH-1:0] r1_idx_d, r1_idx_q;
  logic                 rsp_valid_d, rsp_valid_q;
  logic [IDX_WIDTH-1:0] rsp_idx_d, rsp_idx_q;
  logic [63:0]          rsp_data_d, rsp_data_q;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latches).
    event_d = event_in;
    ovf_d   = ovf_q;
    for (int i = 0; i < N_EVENTS; i++) begin
      cnt_d[i] = cnt_q[i];
      // A clear wins over the E1 event for the same counter; that event is dropped.
      if (clr_all || (clr_valid && (clr_idx == IDX_WIDTH'(i)))) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (event_q[i]) begin
        if (cnt_q[i] == CTR_MAX) begin
          ovf_d[i] = 1'b1;
`ifdef CCI_MPF_EVENT_CTR_SATURATE_EN
          cnt_d[i] = CTR_MAX;
`else
          cnt_d[i] = '0;
`endif
        end else begin
          cnt_d[i] = cnt_q[i] + CTR_WIDTH'(1);
        end
      end
    end
  end

  always_comb begin
    r1_valid_d  = rd_valid;
    r1_idx_d    = rd_idx;
    rsp_valid_d = r1_valid_q;
    rsp_idx_d   = rsp_idx_q;
    rsp_data_d  = rsp_data_q;
    // Snapshot uses the pre-edge counter state, so same-cycle increments/clears are not visible.
    if (r1_valid_q) begin
      rsp_idx_d  = r1_idx_q;
      rsp_data_d = '0;
      for (int i = 0; i < N_EVENTS; i++) begin
        if (r1_idx_q == IDX_WIDTH'(i)) begin
          rsp_data_d = {ovf_q[i], {(63-CTR_WIDTH){1'b0}}, cnt_q[i]};
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      event_q     <= '0;
      ovf_q       <= '0;
      r1_valid_q  <= 1'b0;
      r1_idx_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_idx_q   <= '0;
      rsp_data_q  <= '0;
      // NOTE: the counter array is a small flop bank, not a RAM, so it can and must be reset.
      for (int i = 0; i < N_EVENTS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      event_q     <= event_d;
      ovf_q       <= ovf_d;
      r1_valid_q  <= r1_valid_d;
      r1_idx_q    <= r1_idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_idx_q   <= rsp_idx_d;
      rsp_data_q  <= rsp_data_d;
      for (int i = 0; i < N_EVENTS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign rd_rsp_valid = rsp_valid_q;
  assign rd_rsp_idx   = rsp_idx_q;
  assign rd_rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_cci_mpf_event_counters.sv
// Self-checking bench for cci_mpf_event_counters (8-bit counters so wrap/saturation is reachable).
// The reference model tracks total events since the last clear and derives count/ovf arithmetically.
module tb_cci_mpf_event_counters;

  localparam int N  = 13;
  localparam int CW = 8;
  localparam int IW = 4;
  localparam longint MAXC = (64'd1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  event_in;
  logic          clr_all;
  logic          clr_valid;
  logic [IW-1:0] clr_idx;
  logic          rd_valid;
  logic [IW-1:0] rd_idx;
  logic          rd_rsp_valid;
  logic [IW-1:0] rd_rsp_idx;
  logic [63:0]   rd_rsp_data;

  cci_mpf_event_counters #(.N_EVENTS(N), .CTR_WIDTH(CW), .IDX_WIDTH(IW)) dut (
    .clk          (clk),
    .reset        (reset),
    .event_in     (event_in),
    .clr_all      (clr_all),
    .clr_valid    (clr_valid),
    .clr_idx      (clr_idx),
    .rd_valid     (rd_valid),
    .rd_idx       (rd_idx),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_idx   (rd_rsp_idx),
    .rd_rsp_data  (rd_rsp_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int due; int idx; } rd_req_t;

  longint       tot [N];          // events counted since last clear (unbounded)
  logic [N-1:0] ev_sampled;       // events seen at the previous edge, counted at this one
  rd_req_t      rq [$];
  int           edge_no = 0;
  logic         exp_v;
  logic [IW-1:0] exp_idx;
  logic [63:0]  exp_data;

  function automatic logic [63:0] fmt(input int idx);
    logic [63:0] d;
    longint c;
    if (idx >= N) return 64'h0;
`ifdef CCI_MPF_EVENT_CTR_SATURATE_EN
    c = (tot[idx] > MAXC) ? MAXC : tot[idx];
`else
    c = tot[idx] % (MAXC + 1);
`endif
    d = 64'(c);
    d[63] = (tot[idx] > MAXC);
    return d;
  endfunction

  task automatic model_edge();
    rd_req_t r;
    edge_no++;
    if (reset) begin
      for (int i = 0; i < N; i++) tot[i] = 0;
      ev_sampled = '0;
      rq.delete();
      exp_v = 1'b0; exp_idx = '0; exp_data = '0;
      return;
    end
    exp_v = 1'b0;
    if (rq.size() > 0 && rq[0].due == edge_no) begin
      r = rq.pop_front();
      exp_v    = 1'b1;
      exp_idx  = IW'(r.idx);
      exp_data = fmt(r.idx);
    end
    for (int i = 0; i < N; i++) begin
      if (clr_all || (clr_valid && int'(clr_idx) == i)) tot[i] = 0;
      else if (ev_sampled[i]) tot[i] = tot[i] + 1;
    end
    ev_sampled = event_in;
    if (rd_valid) rq.push_back('{edge_no + 1, int'(rd_idx)});
  endtask

  // Inputs change at negedge; model advances at posedge; outputs are compared at the next negedge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("rsp_valid", 64'(rd_rsp_valid), 64'(exp_v));
    check("rsp_idx",   64'(rd_rsp_idx),   64'(exp_idx));
    check("rsp_data",  rd_rsp_data,       exp_data);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic read_expect(input int idx, input logic [63:0] exp);
    rd_valid = 1'b1; rd_idx = IW'(idx);
    tick();
    rd_valid = 1'b0;
    tick();
    check("direct_valid", 64'(rd_rsp_valid), 64'd1);
    check("direct_idx",   64'(rd_rsp_idx),   64'(idx));
    check("direct_data",  rd_rsp_data,       exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] prev;
    bit          have_prev;
    int          n_rsp;

    reset = 1'b1; event_in = '0; clr_all = 1'b0; clr_valid = 1'b0;
    clr_idx = '0; rd_valid = 1'b0; rd_idx = '0;
    @(negedge clk);
    idle(2);
    check("reset_valid", 64'(rd_rsp_valid), 64'd0);
    check("reset_data",  rd_rsp_data,       64'd0);
    reset = 1'b0;

    // Back-to-back reads of every index after reset.
    n_rsp = 0;
    for (int i = 0; i < N; i++) begin
      rd_valid = 1'b1; rd_idx = IW'(i);
      tick();
      if (rd_rsp_valid) n_rsp++;
    end
    rd_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (rd_rsp_valid) n_rsp++;
    end
    check("reset_read_count", 64'(n_rsp), 64'(N));

    // Event 3: five isolated pulses plus ten consecutive cycles.
    for (int i = 0; i < 5; i++) begin
      event_in = 13'(1 << 3); tick();
      event_in = '0;          tick();
    end
    event_in = 13'(1 << 3);
    idle(10);
    event_in = '0;
    idle(2);
    read_expect(3, 64'd15);
    read_expect(0, 64'd0);
    read_expect(12, 64'd0);

    // Clear of counter 5 discards the coincident E1 event, but the next-cycle event counts.
    event_in = 13'(1 << 5); tick();
    clr_valid = 1'b1; clr_idx = 4'd5; tick();
    clr_valid = 1'b0; event_in = '0;
    idle(2);
    read_expect(5, 64'd1);

    // Out-of-range clear has no effect on counter 3.
    clr_valid = 1'b1; clr_idx = 4'd14; tick();
    clr_valid = 1'b0;
    read_expect(3, 64'd15);

    // 255 then 256 events on bit 0.
    event_in = 13'd1;
    idle(255);
    event_in = '0;
    idle(2);
    read_expect(0, 64'h0000_0000_0000_00FF);
    event_in = 13'd1; tick();
    event_in = '0;
    idle(2);
`ifdef CCI_MPF_EVENT_CTR_SATURATE_EN
    read_expect(0, 64'h8000_0000_0000_00FF);
`else
    read_expect(0, 64'h8000_0000_0000_0000);
`endif
    clr_all = 1'b1; tick();
    clr_all = 1'b0;
    read_expect(0, 64'd0);
    read_expect(3, 64'd0);

    // Full-throughput reads of idx 2 while it increments every cycle.
    event_in = 13'(1 << 2); rd_valid = 1'b1; rd_idx = 4'd2;
    have_prev = 1'b0; n_rsp = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (rd_rsp_valid) begin
        n_rsp++;
        if (have_prev) check("b2b_step", rd_rsp_data - prev, 64'd1);
        prev = rd_rsp_data; have_prev = 1'b1;
      end
    end
    event_in = '0; rd_valid = 1'b0;
    idle(2);
    check("b2b_count", 64'(n_rsp), 64'd23);

    // Out-of-range read index.
    read_expect(15, 64'd0);

    // Reset one cycle after a read drops the response.
    rd_valid = 1'b1; rd_idx = 4'd3; tick();
    rd_valid = 1'b0; reset = 1'b1; tick();
    check("drop_valid_a", 64'(rd_rsp_valid), 64'd0);
    reset = 1'b0; tick();
    check("drop_valid_b", 64'(rd_rsp_valid), 64'd0);
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      event_in  = N'($urandom) & N'($urandom);
      clr_all   = ($urandom_range(0, 299) == 0);
      clr_valid = ($urandom_range(0, 15) == 0);
      clr_idx   = IW'($urandom_range(0, 15));
      rd_valid  = ($urandom_range(0, 1) == 1);
      rd_idx    = IW'($urandom_range(0, 15));
      reset     = ($urandom_range(0, 799) == 0);
      tick();
    end
    reset = 1'b0; event_in = '0; clr_all = 1'b0; clr_valid = 1'b0; rd_valid = 1'b0;
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
